// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the byte-writable dual-port RAM.
// Default geometry constants, clear-sequencer state encoding, byte parity.
package dp_ram_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;
    localparam int BYTES      = DATA_W_DEF / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Even parity: the stored bit makes the byte plus parity have an even count of ones.
    function automatic logic byte_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dp_ram_clear_seq.sv
// Clear sequencer: sweeps every address with zero after reset or on clear_req,
// then holds ready high until the next clear request.
module dp_ram_clear_seq
    import dp_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic                ready_q, ready_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            CLEAR: begin
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == {ADDR_W{1'b1}}) state_d = READY;
            end
            READY: begin
                if (clear_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
        ready_d = (state_d == READY);
    end

    assign clr_we   = (state_q == CLEAR);
    assign clr_addr = clr_addr_q;
    assign ready    = ready_q;

endmodule

// File: rtl/dp_ram_bytewr.sv
// Simple dual-port RAM with byte enables, 1-cycle registered read, write-first bypass
// and a hardware zero-clear sweep. Define MEM_PARITY_EN for per-byte even parity.
module dp_ram_bytewr
    import dp_ram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    input  logic                clear_req,
`ifdef MEM_PARITY_EN
    input  logic                wr_perr_inj,
    output logic [DATA_W/8-1:0] rd_perr,
`endif
    output logic                ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              host_we, host_rd;
    logic [LANES-1:0]  lane_we, byp;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, fwd_data;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    dp_ram_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .ready     (ready)
    );

    assign host_we = ready & wr_en;
    assign host_rd = ready & rd_en;

    // The sweep owns the write port while ready is low; host writes are gated off then.
    assign lane_we   = clr_we ? {LANES{1'b1}} : (host_we ? wr_be : '0);
    assign mem_addr  = clr_we ? clr_addr : wr_addr;
    assign mem_wdata = clr_we ? '0 : wr_data;

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (lane_we[l]) mem[mem_addr][8*l +: 8] <= mem_wdata[8*l +: 8];
        end
    end

    always_comb begin
        fwd_data = mem[rd_addr];
        for (int l = 0; l < LANES; l++) begin
            byp[l] = host_we & wr_be[l] & (wr_addr == rd_addr);
            if (byp[l]) fwd_data[8*l +: 8] = wr_data[8*l +: 8];
        end
        rd_valid_d = host_rd;
        rd_data_d  = host_rd ? fwd_data : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

`ifdef MEM_PARITY_EN
    logic [LANES-1:0] par_mem [DEPTH];
    logic [LANES-1:0] wr_par, mem_wpar, fwd_par, perr_d, rd_perr_q;

    always_comb begin
        wr_par = '0;
        for (int l = 0; l < LANES; l++) wr_par[l] = byte_par(wr_data[8*l +: 8]);
        wr_par[0] = wr_par[0] ^ wr_perr_inj;
        mem_wpar  = clr_we ? '0 : wr_par;
        fwd_par   = par_mem[rd_addr];
        perr_d    = '0;
        for (int l = 0; l < LANES; l++) begin
            if (byp[l]) fwd_par[l] = wr_par[l];
            perr_d[l] = byte_par(fwd_data[8*l +: 8]) ^ fwd_par[l];
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (lane_we[l]) par_mem[mem_addr][l] <= mem_wpar[l];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_perr_q <= '0;
        else        rd_perr_q <= host_rd ? perr_d : '0;
    end

    assign rd_perr = rd_perr_q;
`endif

endmodule

// File: tb/tb_dp_ram_bytewr.sv
// Randomised self-checking bench for dp_ram_bytewr against a word-array reference model.
module tb_dp_ram_bytewr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, rd_en, clear_req, wr_perr_inj;
    logic [7:0]  wr_addr, rd_addr;
    logic [15:0] wr_data, rd_data;
    logic [1:0]  wr_be, rd_perr;
    logic        rd_valid, ready;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] ref_mem [256];
    logic [1:0]  ref_bad [256];
    logic [15:0] exp_rd, last_rd;
    logic        exp_rv;
    logic [1:0]  exp_perr;

    always #5 clk = ~clk;

    dp_ram_bytewr #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_be       (wr_be),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .clear_req   (clear_req),
`ifdef MEM_PARITY_EN
        .wr_perr_inj (wr_perr_inj),
        .rd_perr     (rd_perr),
`endif
        .ready       (ready)
    );

`ifndef MEM_PARITY_EN
    assign rd_perr = 2'b00;
`endif

    task automatic model_zero();
        for (int a = 0; a < 256; a++) begin
            ref_mem[a] = 16'h0000;
            ref_bad[a] = 2'b00;
        end
    endtask

    // One READY-state cycle: predict the read (write-first per lane), update model, apply edge.
    task automatic cyc(input logic we, input logic [7:0] wa, input logic [15:0] wd,
                       input logic [1:0] be, input logic re, input logic [7:0] ra,
                       input logic cr, input logic inj);
        exp_rv   = re;
        exp_perr = 2'b00;
        exp_rd   = last_rd;
        if (re) begin
            for (int l = 0; l < 2; l++) begin
                if (we && be[l] && wa == ra) begin
                    exp_rd[8*l +: 8] = wd[8*l +: 8];
                    exp_perr[l]      = (l == 0) ? inj : 1'b0;
                end else begin
                    exp_rd[8*l +: 8] = ref_mem[ra][8*l +: 8];
                    exp_perr[l]      = ref_bad[ra][l];
                end
            end
            last_rd = exp_rd;
        end
        if (we) begin
            for (int l = 0; l < 2; l++) begin
                if (be[l]) begin
                    ref_mem[wa][8*l +: 8] = wd[8*l +: 8];
                    ref_bad[wa][l]        = (l == 0) ? inj : 1'b0;
                end
            end
        end
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra; clear_req = cr; wr_perr_inj = inj;
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0; clear_req = 0; wr_perr_inj = 0; wr_be = 2'b00;
    endtask

    task automatic check_read(input string name);
        n_vec++;
        if (rd_valid !== exp_rv) begin
            n_err++;
            $display("FAIL %s rd_valid: got %b want %b", name, rd_valid, exp_rv);
        end
        n_vec++;
        if (rd_data !== exp_rd) begin
            n_err++;
            $display("FAIL %s rd_data: got %h want %h", name, rd_data, exp_rd);
        end
`ifdef MEM_PARITY_EN
        n_vec++;
        if (rd_perr !== exp_perr) begin
            n_err++;
            $display("FAIL %s rd_perr: got %b want %b", name, rd_perr, exp_perr);
        end
`endif
    endtask

    // Count edges with ready low, starting from the current cycle; expect exactly n.
    task automatic sweep_wait(input string name, input int n);
        int low_bad;
        logic [15:0] held;
        low_bad = 0;
        held = rd_data;
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1; rd_addr = 8'($urandom_range(0, 255));
            wr_en = 1'b1; wr_addr = rd_addr; wr_data = 16'hDEAD; wr_be = 2'b11;
            if (ready !== 1'b0) low_bad++;
            @(posedge clk); #1;
            if (rd_valid !== 1'b0 || rd_data !== held) low_bad++;
        end
        rd_en = 0; wr_en = 0; wr_be = 2'b00;
        n_vec++;
        if (low_bad != 0) begin
            n_err++;
            $display("FAIL %s sweep: got %0d bad cycles want 0", name, low_bad);
        end
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_after_sweep: got %b want 1", name, ready);
        end
        model_zero();
    endtask

    task automatic test_reset();
        rst_n = 0; wr_en = 0; rd_en = 0; clear_req = 0; wr_perr_inj = 0;
        wr_addr = 0; rd_addr = 0; wr_data = 0; wr_be = 0;
        last_rd = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (rd_data !== 16'h0 || rd_valid !== 1'b0 || ready !== 1'b0 || rd_perr !== 2'b00) begin
            n_err++;
            $display("FAIL reset_values: got data=%h vld=%b rdy=%b want 0000 0 0",
                     rd_data, rd_valid, ready);
        end
        rst_n = 1;
        sweep_wait("reset", 256);
        cyc(0, 0, 0, 0, 1, 8'h00, 0, 0); check_read("reset_rd00");
        cyc(0, 0, 0, 0, 1, 8'h7F, 0, 0); check_read("reset_rd7F");
        cyc(0, 0, 0, 0, 1, 8'hFF, 0, 0); check_read("reset_rdFF");
    endtask

    task automatic test_write_read();
        cyc(1, 8'h10, 16'hA55A, 2'b11, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 8'h10, 0, 0); check_read("wr_rd");
        n_vec++;
        if (rd_data !== 16'hA55A) begin
            n_err++;
            $display("FAIL wr_rd_const: got %h want a55a", rd_data);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0); check_read("wr_rd_strobe_drop");
    endtask

    task automatic test_byte_enable();
        cyc(1, 8'h20, 16'h1234, 2'b11, 0, 0, 0, 0);
        cyc(1, 8'h20, 16'hFFFF, 2'b01, 0, 0, 0, 0);
        cyc(1, 8'h20, 16'h0000, 2'b00, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 8'h20, 0, 0); check_read("byte_en");
        n_vec++;
        if (rd_data !== 16'h12FF) begin
            n_err++;
            $display("FAIL byte_en_const: got %h want 12ff", rd_data);
        end
    endtask

    task automatic test_collision();
        cyc(1, 8'h20, 16'hBEEF, 2'b10, 1, 8'h20, 0, 0); check_read("collide");
        n_vec++;
        if (rd_data !== 16'hBEFF) begin
            n_err++;
            $display("FAIL collide_const: got %h want beff", rd_data);
        end
        cyc(0, 0, 0, 0, 1, 8'h20, 0, 0); check_read("collide_after");
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom), 2'($urandom),
                1'($urandom), 8'($urandom_range(0, 15)), 0,
`ifdef MEM_PARITY_EN
                1'($urandom)
`else
                1'b0
`endif
            );
            check_read("random");
        end
    endtask

    task automatic test_clear();
        cyc(1, 8'h21, 16'h5555, 2'b11, 1, 8'h20, 1, 0); check_read("clear_req_cycle");
        sweep_wait("clear", 256);
        cyc(0, 0, 0, 0, 1, 8'h20, 0, 0); check_read("clear_rd20");
        cyc(0, 0, 0, 0, 1, 8'h21, 0, 0); check_read("clear_rd21");
    endtask

    task automatic test_reset_mid_sweep();
        cyc(1, 8'h30, 16'hC0DE, 2'b11, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 8'h30, 0, 0); check_read("pre_rst_read");
        rst_n = 0; #2;
        n_vec++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h0 || ready !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got vld=%b data=%h rdy=%b want 0 0000 0",
                     rd_valid, rd_data, ready);
        end
        rst_n = 1; last_rd = 16'h0000;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 0; #2; rst_n = 1;
        sweep_wait("mid_sweep_rst", 256);
        cyc(0, 0, 0, 0, 1, 8'h30, 0, 0); check_read("mid_rst_rd30");
    endtask

`ifdef MEM_PARITY_EN
    task automatic test_parity();
        cyc(1, 8'h05, 16'h00FF, 2'b11, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 8'h05, 0, 0); check_read("perr_inj");
        n_vec++;
        if (rd_perr !== 2'b01) begin
            n_err++;
            $display("FAIL perr_inj_const: got %b want 01", rd_perr);
        end
        cyc(1, 8'h05, 16'h00FF, 2'b11, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 8'h05, 0, 0); check_read("perr_clean");
        cyc(1, 8'h06, 16'h1234, 2'b11, 1, 8'h06, 0, 1); check_read("perr_bypass");
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_collision();
`ifdef MEM_PARITY_EN
        test_parity();
`endif
        test_random();
        test_clear();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
